// File: rtl/writeback_ctrl.sv
// writeback_ctrl
//
// Sequencing controller for the register-file writeback path and the
// data-cache handshake of the single-issue CPU. ALU instructions write the
// register file in the same cycle with no stall. Loads and stores stall the
// pipeline while the data cache works. A load that writes a register then
// gets exactly one writeback cycle that selects memory read data. A memory
// transaction whose busy-wait lasts too long parks the controller in a
// sticky error state, which only reset clears.
//
// Parameters:
//   TIMEOUT  busy-wait cycles tolerated in MEM_WAIT before ERROR (1..65535)
//   CNT_W    width of STALL_COUNT
//
// Ports:
//   CLK              system clock, rising edge
//   RESET            asynchronous active-low reset
//   INSTR_VALID      decoded instruction present this cycle
//   REG_WRITE        instruction writes a register
//   MEM_READ         load instruction
//   MEM_WRITE        store instruction
//   DEST_REG         destination register index
//   DCACHE_BUSYWAIT  cache busy, request not complete yet
//   CLR_STATS        synchronous clear of STALL_COUNT
//   DCACHE_READ      read request to data cache
//   DCACHE_WRITE     write request to data cache
//   WRITEMUX_SEL     0 = ALU result, 1 = memory read data
//   WRITEENABLE      register-file write enable
//   WRITEREG         register-file write index
//   STALL            hold PC and instruction
//   TIMEOUT_ERR      sticky hung-memory flag
//   STALL_COUNT      saturating count of stalled cycles

module writeback_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INSTR_VALID,
  input  logic             REG_WRITE,
  input  logic             MEM_READ,
  input  logic             MEM_WRITE,
  input  logic [2:0]       DEST_REG,
  input  logic             DCACHE_BUSYWAIT,
  input  logic             CLR_STATS,
  output logic             DCACHE_READ,
  output logic             DCACHE_WRITE,
  output logic             WRITEMUX_SEL,
  output logic             WRITEENABLE,
  output logic [2:0]       WRITEREG,
  output logic             STALL,
  output logic             TIMEOUT_ERR,
  output logic [CNT_W-1:0] STALL_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    WRITEBACK,
    ERROR
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_t           state, next_state;
  logic [15:0]      wait_cnt, next_wait_cnt;
  logic [2:0]       lat_dest;
  logic             lat_read;
  logic             lat_reg_write;
  logic             req_read_q, req_write_q;
  logic             req_read_next, req_write_next;
  logic             accept;
  logic [CNT_W-1:0] stall_count;

  logic             mux_sel_c, write_en_c, stall_c, timeout_err_c;
  logic [2:0]       write_reg_c;

  // Next-state, request strobes and the combinational pipeline controls.
  // Everything defaults to the quiet value so only the state that owns a
  // signal has to mention it.
  always_comb begin
    next_state     = state;
    next_wait_cnt  = wait_cnt;
    req_read_next  = 1'b0;
    req_write_next = 1'b0;
    accept         = 1'b0;
    mux_sel_c      = 1'b0;
    write_en_c     = 1'b0;
    write_reg_c    = 3'd0;
    stall_c        = 1'b0;
    timeout_err_c  = 1'b0;

    case (state)
      IDLE: begin
        if (INSTR_VALID) begin
          if (MEM_READ || MEM_WRITE) begin
            // A load wins when both op bits are set, so a malformed
            // decode never drives both cache strobes.
            stall_c        = 1'b1;
            accept         = 1'b1;
            next_state     = MEM_WAIT;
            next_wait_cnt  = 16'd0;
            req_read_next  = MEM_READ;
            req_write_next = !MEM_READ;
          end else begin
            write_en_c  = REG_WRITE;
            write_reg_c = DEST_REG;
          end
        end
      end

      MEM_WAIT: begin
        stall_c = 1'b1;
        if (!DCACHE_BUSYWAIT) begin
          next_state = (lat_read && lat_reg_write) ? WRITEBACK : IDLE;
        end else begin
          next_wait_cnt = wait_cnt + 16'd1;
          if (next_wait_cnt == TIMEOUT_L) begin
            next_state = ERROR;
          end else begin
            req_read_next  = lat_read;
            req_write_next = !lat_read;
          end
        end
      end

      WRITEBACK: begin
        // The cache keeps read data stable until its next request, so
        // the memory path can be written one cycle after completion.
        mux_sel_c   = 1'b1;
        write_en_c  = 1'b1;
        write_reg_c = lat_dest;
        stall_c     = 1'b1;
        next_state  = IDLE;
      end

      ERROR: begin
        stall_c       = 1'b1;
        timeout_err_c = 1'b1;
      end

      default: next_state = IDLE;
    endcase
  end

  // State, latched instruction fields, registered cache strobes and the
  // stall statistics counter. Clear beats increment on the counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      wait_cnt      <= 16'd0;
      lat_dest      <= 3'd0;
      lat_read      <= 1'b0;
      lat_reg_write <= 1'b0;
      req_read_q    <= 1'b0;
      req_write_q   <= 1'b0;
      stall_count   <= '0;
    end else begin
      state       <= next_state;
      wait_cnt    <= next_wait_cnt;
      req_read_q  <= req_read_next;
      req_write_q <= req_write_next;
      if (accept) begin
        lat_dest      <= DEST_REG;
        lat_read      <= MEM_READ;
        lat_reg_write <= REG_WRITE;
      end
      if (CLR_STATS) begin
        stall_count <= '0;
      end else if (stall_c && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // The combinational controls depend on live instruction inputs, so they
  // are masked by reset to keep every output low while reset is held.
  always_comb begin
    DCACHE_READ  = req_read_q;
    DCACHE_WRITE = req_write_q;
    STALL_COUNT  = stall_count;
    WRITEMUX_SEL = mux_sel_c && RESET;
    WRITEENABLE  = write_en_c && RESET;
    WRITEREG     = RESET ? write_reg_c : 3'd0;
    STALL        = stall_c && RESET;
    TIMEOUT_ERR  = timeout_err_c && RESET;
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// tb_writeback_ctrl
//
// Bench for writeback_ctrl. Two instances share all inputs: dut_a with the
// default parameters and dut_b with TIMEOUT=4 and CNT_W=4, so that hung
// transactions and counter saturation show up on dut_b. Expected outputs
// come from a transaction-level view: each memory op is a sequence of cycles
// numbered from the accept cycle, and the outputs of every cycle follow from
// that index, the op kind and the number of busy-wait cycles.

module tb_writeback_ctrl;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       sel;
    logic       we;
    logic [2:0] wreg;
    logic       stall;
    logic       err;
  } exp_t;

  logic       CLK;
  logic       RESET;
  logic       instr_valid, reg_write, mem_read, mem_write, busywait, clr_stats;
  logic [2:0] dest_reg;

  logic        a_rd, a_wr, a_sel, a_we, a_stall, a_err;
  logic [2:0]  a_wreg;
  logic [15:0] a_cnt;
  logic        b_rd, b_wr, b_sel, b_we, b_stall, b_err;
  logic [2:0]  b_wreg;
  logic [3:0]  b_cnt;

  int check_count = 0;
  int fail_count  = 0;
  int cycle_no    = 0;
  int cnt_a       = 0;
  int cnt_b       = 0;
  bit allow_clr   = 0;
  int force_clr_at = -1;

  writeback_ctrl dut_a (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(instr_valid), .REG_WRITE(reg_write),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .DEST_REG(dest_reg),
    .DCACHE_BUSYWAIT(busywait), .CLR_STATS(clr_stats),
    .DCACHE_READ(a_rd), .DCACHE_WRITE(a_wr), .WRITEMUX_SEL(a_sel),
    .WRITEENABLE(a_we), .WRITEREG(a_wreg), .STALL(a_stall),
    .TIMEOUT_ERR(a_err), .STALL_COUNT(a_cnt)
  );

  writeback_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(instr_valid), .REG_WRITE(reg_write),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .DEST_REG(dest_reg),
    .DCACHE_BUSYWAIT(busywait), .CLR_STATS(clr_stats),
    .DCACHE_READ(b_rd), .DCACHE_WRITE(b_wr), .WRITEMUX_SEL(b_sel),
    .WRITEENABLE(b_we), .WRITEREG(b_wreg), .STALL(b_stall),
    .TIMEOUT_ERR(b_err), .STALL_COUNT(b_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d",
               tag, cycle_no, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rw, input logic mr,
                               input logic mw, input logic [2:0] dest,
                               input logic busy, input logic clr);
    instr_valid = valid;
    reg_write   = rw;
    mem_read    = mr;
    mem_write   = mw;
    dest_reg    = dest;
    busywait    = busy;
    clr_stats   = clr;
  endtask

  // Expected outputs for cycle c of a memory op on a controller with the
  // given timeout. Cycle 0 is the accept cycle, cycles 1..n+1 wait on the
  // cache, then an optional writeback; a busy-wait of t or more cycles ends
  // in the error state after the t-th wait cycle.
  function automatic exp_t txn_expect(int t, bit is_read, bit load_wb,
                                      logic [2:0] dest, int n, int c);
    exp_t e = '0;
    e.stall = 1'b1;
    if (c == 0) return e;
    if (n >= t) begin
      if (c <= t) begin
        e.rd = is_read;
        e.wr = !is_read;
      end else begin
        e.err = 1'b1;
      end
      return e;
    end
    if (c <= n + 1) begin
      e.rd = is_read;
      e.wr = !is_read;
    end else if (load_wb) begin
      e.sel  = 1'b1;
      e.we   = 1'b1;
      e.wreg = dest;
    end
    return e;
  endfunction

  task automatic check_all(input exp_t ea, input exp_t eb);
    checkOutput("A.dcache_read",  32'(a_rd),    32'(ea.rd));
    checkOutput("A.dcache_write", 32'(a_wr),    32'(ea.wr));
    checkOutput("A.writemux_sel", 32'(a_sel),   32'(ea.sel));
    checkOutput("A.writeenable",  32'(a_we),    32'(ea.we));
    if (ea.we) checkOutput("A.writereg", 32'(a_wreg), 32'(ea.wreg));
    checkOutput("A.stall",        32'(a_stall), 32'(ea.stall));
    checkOutput("A.timeout_err",  32'(a_err),   32'(ea.err));
    checkOutput("A.stall_count",  32'(a_cnt),   32'(cnt_a));
    checkOutput("B.dcache_read",  32'(b_rd),    32'(eb.rd));
    checkOutput("B.dcache_write", 32'(b_wr),    32'(eb.wr));
    checkOutput("B.writemux_sel", 32'(b_sel),   32'(eb.sel));
    checkOutput("B.writeenable",  32'(b_we),    32'(eb.we));
    if (eb.we) checkOutput("B.writereg", 32'(b_wreg), 32'(eb.wreg));
    checkOutput("B.stall",        32'(b_stall), 32'(eb.stall));
    checkOutput("B.timeout_err",  32'(b_err),   32'(eb.err));
    checkOutput("B.stall_count",  32'(b_cnt),   32'(cnt_b));
  endtask

  // Checks one cycle, then crosses the clock edge and advances the
  // statistics counters the way the stall flags say they should.
  task automatic step_cycle(input exp_t ea, input exp_t eb);
    #1;
    check_all(ea, eb);
    @(posedge CLK);
    cycle_no++;
    if (clr_stats) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (ea.stall && cnt_a < 65535) cnt_a++;
      if (eb.stall && cnt_b < 15)    cnt_b++;
    end
    #1;
  endtask

  // Asserts reset away from the clock edge, checks that every output is
  // already low, holds across one edge, then releases at edge+1.
  task automatic reset_duts();
    RESET = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    #1;
    check_all('0, '0);
    @(posedge CLK);
    cycle_no++;
    #1;
    RESET = 1'b1;
  endtask

  task automatic alu_cycle(input logic valid, input logic rw, input logic [2:0] dest);
    exp_t e;
    logic clr;
    clr = allow_clr && ($urandom_range(0, 15) == 0);
    applyStimulus(valid, rw, 1'b0, 1'b0, dest, 1'($urandom_range(0, 1)), clr);
    e      = '0;
    e.we   = valid && rw;
    e.wreg = dest;
    step_cycle(e, e);
  endtask

  // Drives one memory op for as many cycles as dut_a needs; abort_at >= 0
  // pulls reset in the middle of that cycle instead of finishing.
  task automatic run_txn(input logic mr, input logic mw, input logic rw,
                         input logic [2:0] dest, input int n, input int abort_at);
    bit   is_read, load_wb;
    int   len_a;
    logic clr;
    exp_t ea, eb;
    is_read = mr;
    load_wb = mr && rw;
    len_a   = n + 2 + (load_wb ? 1 : 0);
    for (int c = 0; c < len_a; c++) begin
      clr = (c == force_clr_at) || (allow_clr && ($urandom_range(0, 15) == 0));
      applyStimulus(1'b1, rw, mr, mw, dest, (c >= 1 && c <= n), clr);
      ea = txn_expect(255, is_read, load_wb, dest, n, c);
      eb = txn_expect(4,   is_read, load_wb, dest, n, c);
      if (c == abort_at) begin
        #1;
        check_all(ea, eb);
        reset_duts();
        return;
      end
      step_cycle(ea, eb);
    end
    if (n >= 4) reset_duts();
  endtask

  initial begin
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    reset_duts();

    // ALU op, then an idle cycle.
    alu_cycle(1'b1, 1'b1, 3'd5);
    alu_cycle(1'b0, 1'b0, 3'd0);

    // Load hit: three stall cycles, writeback to r3, count lands on 3.
    run_txn(1'b1, 1'b0, 1'b1, 3'd3, 0, -1);
    alu_cycle(1'b0, 1'b0, 3'd0);

    // Store miss with 20 busy cycles; dut_b times out along the way.
    run_txn(1'b0, 1'b1, 1'b1, 3'd6, 20, -1);
    alu_cycle(1'b1, 1'b1, 3'd2);

    // Both op bits set is a load; then a load with no register write.
    run_txn(1'b1, 1'b1, 1'b1, 3'd7, 2, -1);
    run_txn(1'b1, 1'b0, 1'b0, 3'd4, 1, -1);

    // Hung load, reset pulled in the middle of the wait, then an ALU op.
    run_txn(1'b1, 1'b0, 1'b1, 3'd1, 50, 7);
    alu_cycle(1'b1, 1'b1, 3'd6);

    // Twenty stall cycles saturate dut_b's 4-bit counter.
    for (int k = 0; k < 4; k++) run_txn(1'b1, 1'b0, 1'b1, 3'(k), 2, -1);
    alu_cycle(1'b0, 1'b0, 3'd0);

    // Clear pulsed during a stall cycle.
    force_clr_at = 2;
    run_txn(1'b0, 1'b1, 1'b0, 3'd0, 3, -1);
    force_clr_at = -1;
    alu_cycle(1'b0, 1'b0, 3'd0);

    // Randomized mix of ALU ops, idle cycles and memory ops.
    allow_clr = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        alu_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
      end else begin
        logic mr, mw;
        int   n;
        mr = 1'($urandom_range(0, 1));
        mw = mr ? 1'($urandom_range(0, 1)) : 1'b1;
        n  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 25) : $urandom_range(0, 5);
        run_txn(mr, mw, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), n, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             check_count, fail_count);
    $finish;
  end

endmodule
